axi4_lite_uart_bridge_master: RTL and testbench

//  UART-controlled AXI4-Lite initiator: receives 8N1 command frames on rx, issues one AXI4-Lite write or read,
//  and returns status/read data on tx. Host-side bus master for the AXI4-Lite UART slave and other 32-bit slaves.

---
 rtl/axi4_lite_uart_bridge_master.sv | 232 +++++++++++++++++++++++
 tb/tb_axi4_lite_uart_bridge_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_uart_bridge_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : axi4_lite_uart_bridge_master                                      |
// | Brief   : 8N1 UART command frames in, one AXI4-Lite write/read out, status  |
// |           and read data returned on tx. Optional macro:                     |
// |           UART_BRIDGE_FRAME_TIMEOUT_EN (inter-byte frame timeout).          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module axi4_lite_uart_bridge_master #(
   parameter int CLKS_PER_BIT   = 10417,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic        aclk,
   input  logic        areset,
   output logic [31:0] awaddr_out,
   output logic [2:0]  awprot_out,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata_out,
   output logic [3:0]  wstrb_out,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic [31:0] araddr_out,
   output logic [2:0]  arprot_out,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata_in,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic        tx,
   input  logic        rx
);

   localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0]       CMD_WR   = 8'h57;
   localparam logic [7:0]       CMD_RD   = 8'h52;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_AXI_W, S_AXI_B, S_AXI_AR, S_AXI_R, S_RESP
   } state_t;

   state_t            state, state_nxt;
   logic              rx_s1, rx_s2, rx_prev, rx_busy, rx_valid, rx_ferr;
   logic [3:0]        rx_idx;
   logic [CNT_W-1:0]  rx_cnt;
   logic [7:0]        rx_shift;
   logic              tx_busy, tx_ready, tx_load;
   logic [3:0]        tx_idx;
   logic [CNT_W-1:0]  tx_cnt;
   logic [9:0]        tx_shift;
   logic [31:0]       addr, wdata;
   logic [1:0]        byte_cnt;
   logic              is_write, aw_done, w_done, aw_hs, w_hs, frame_timeout;
   logic [39:0]       resp_shift;
   logic [2:0]        resp_left;

   assign awprot_out = 3'b000;
   assign arprot_out = 3'b000;
   assign wstrb_out  = 4'b1111;
   assign awaddr_out = addr;
   assign araddr_out = addr;
   assign wdata_out  = wdata;
   assign awvalid    = (state == S_AXI_W) && !aw_done;
   assign wvalid     = (state == S_AXI_W) && !w_done;
   assign bready     = (state == S_AXI_B);
   assign arvalid    = (state == S_AXI_AR);
   assign rready     = (state == S_AXI_R);
   assign aw_hs      = awvalid && awready;
   assign w_hs       = wvalid && wready;
   assign tx         = tx_shift[0];

   // Receiver: index 0 is the start bit (checked at half bit), 1..8 data, 9 stop.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
         rx_busy <= 1'b0; rx_idx <= '0; rx_cnt <= '0; rx_shift <= '0;
         rx_valid <= 1'b0; rx_ferr <= 1'b0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (!rx_busy) begin
            if (rx_prev && !rx_s2) begin
               rx_busy <= 1'b1; rx_idx <= '0; rx_cnt <= '0;
            end
         end else if (rx_idx == 4'd0) begin
            if (rx_cnt == HALF_BIT) begin
               rx_cnt <= '0;
               if (rx_s2) rx_busy <= 1'b0;
               else       rx_idx  <= 4'd1;
            end else begin
               rx_cnt <= rx_cnt + CNT_W'(1);
            end
         end else if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            if (rx_idx == 4'd9) begin
               rx_busy  <= 1'b0;
               rx_valid <= rx_s2;
               rx_ferr  <= !rx_s2;
            end else begin
               rx_shift <= {rx_s2, rx_shift[7:1]};
               rx_idx   <= rx_idx + 4'd1;
            end
         end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
         end
      end
   end

   // A new byte may load in the last cycle of a stop bit so bytes go back-to-back.
   assign tx_ready = !tx_busy || (tx_idx == 4'd9 && tx_cnt == BIT_END);

   always_ff @(posedge aclk) begin
      if (areset) begin
         tx_busy <= 1'b0; tx_idx <= '0; tx_cnt <= '0; tx_shift <= '1;
      end else if (tx_load) begin
         tx_shift <= {1'b1, resp_shift[7:0], 1'b0};
         tx_busy  <= 1'b1; tx_idx <= '0; tx_cnt <= '0;
      end else if (tx_busy) begin
         if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_idx == 4'd9) tx_busy <= 1'b0;
            else                tx_idx  <= tx_idx + 4'd1;
         end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
         end
      end
   end

`ifdef UART_BRIDGE_FRAME_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   assign frame_timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES));

   always_ff @(posedge aclk) begin
      if (areset) begin
         to_cnt <= '0;
      end else if (!(state == S_ADDR || state == S_DATA) || rx_valid) begin
         to_cnt <= '0;
      end else if (!frame_timeout) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end
`else
   assign frame_timeout = 1'b0;
`endif

   always_ff @(posedge aclk) begin
      if (areset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_load   = 1'b0;
      case (state)
         S_IDLE:   if (rx_valid && (rx_byte_is_cmd(rx_shift))) state_nxt = S_ADDR;
         S_ADDR: begin
            if (rx_ferr || frame_timeout)        state_nxt = S_IDLE;
            else if (rx_valid && byte_cnt == 2'd3) state_nxt = is_write ? S_DATA : S_AXI_AR;
         end
         S_DATA: begin
            if (rx_ferr || frame_timeout)        state_nxt = S_IDLE;
            else if (rx_valid && byte_cnt == 2'd3) state_nxt = S_AXI_W;
         end
         S_AXI_W:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_AXI_B;
         S_AXI_B:  if (bvalid)  state_nxt = S_RESP;
         S_AXI_AR: if (arready) state_nxt = S_AXI_R;
         S_AXI_R:  if (rvalid)  state_nxt = S_RESP;
         S_RESP: begin
            if (resp_left != 3'd0) tx_load = tx_ready;
            else if (!tx_busy)     state_nxt = S_IDLE;
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   function automatic logic rx_byte_is_cmd(input logic [7:0] b);
      return (b == CMD_WR) || (b == CMD_RD);
   endfunction

   always_ff @(posedge aclk) begin
      if (areset) begin
         addr <= '0; wdata <= '0; byte_cnt <= '0; is_write <= 1'b0;
         aw_done <= 1'b0; w_done <= 1'b0; resp_shift <= '0; resp_left <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               byte_cnt <= '0; aw_done <= 1'b0; w_done <= 1'b0;
               if (rx_valid) is_write <= (rx_shift == CMD_WR);
            end
            S_ADDR: if (rx_valid) begin
               addr[{byte_cnt, 3'b000} +: 8] <= rx_shift;
               byte_cnt <= byte_cnt + 2'd1;
            end
            S_DATA: if (rx_valid) begin
               wdata[{byte_cnt, 3'b000} +: 8] <= rx_shift;
               byte_cnt <= byte_cnt + 2'd1;
            end
            S_AXI_W: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            S_AXI_B: if (bvalid) begin
               resp_shift <= {32'h0, 6'b0, bresp};
               resp_left  <= 3'd1;
            end
            S_AXI_R: if (rvalid) begin
               resp_shift <= {rdata_in, 6'b0, rresp};
               resp_left  <= 3'd5;
            end
            S_RESP: if (tx_load) begin
               resp_shift <= {8'h00, resp_shift[39:8]};
               resp_left  <= resp_left - 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_uart_bridge_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_axi4_lite_uart_bridge_master                                   |
// | Brief   : Directed bench: UART frames in, AXI4-Lite slave model, tx decoder.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_axi4_lite_uart_bridge_master;

   localparam int CPB = 16;
   localparam int TOC = 1000;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] awaddr_out, wdata_out, araddr_out, rdata_in;
   logic [2:0]  awprot_out, arprot_out;
   logic [3:0]  wstrb_out;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, tx;
   logic        rx = 1'b1;
   logic [1:0]  bresp, rresp;

   int errors = 0;
   int checks = 0;

   // slave model state
   int          aw_delay = 0;
   logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
   logic [31:0] s_rdata = '0;
   int          aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n, aw_hi_n, w_hi_n, ar_hi_n, aw_unstable;
   logic [31:0] aw_first, seen_awaddr, seen_wdata, seen_araddr;
   logic [3:0]  seen_wstrb;
   logic [7:0]  txq[$];

   always #5 clk = ~clk;

   axi4_lite_uart_bridge_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TOC)) dut (
      .aclk(clk), .areset(areset),
      .awaddr_out(awaddr_out), .awprot_out(awprot_out), .awvalid(awvalid), .awready(awready),
      .wdata_out(wdata_out), .wstrb_out(wstrb_out), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr_out(araddr_out), .arprot_out(arprot_out), .arvalid(arvalid), .arready(arready),
      .rdata_in(rdata_in), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .tx(tx), .rx(rx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Slave: readies/responses decided at negedge; handshakes complete at the following posedge.
   initial begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata_in = 0;
      forever begin
         @(negedge clk);
         awready  = awvalid && (aw_hi_n >= aw_delay);
         wready   = wvalid;
         arready  = arvalid;
         bvalid   = (aw_hs_n > b_hs_n) && (w_hs_n > b_hs_n);
         bresp    = s_bresp;
         rvalid   = (ar_hs_n > r_hs_n);
         rresp    = s_rresp;
         rdata_in = s_rdata;
         if (awvalid) begin
            if (aw_hi_n == 0) aw_first = awaddr_out;
            else if (awaddr_out !== aw_first) aw_unstable++;
            aw_hi_n++;
         end
         if (awvalid && awready) begin aw_hs_n++; seen_awaddr = awaddr_out; end
         if (wvalid) w_hi_n++;
         if (wvalid && wready) begin w_hs_n++; seen_wdata = wdata_out; seen_wstrb = wstrb_out; end
         if (arvalid) ar_hi_n++;
         if (arvalid && arready) begin ar_hs_n++; seen_araddr = araddr_out; end
         if (bvalid && bready) b_hs_n++;
         if (rvalid && rready) r_hs_n++;
      end
   end

   // tx decoder: sample each bit near its middle.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            repeat (CPB/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("tx_stop_bit", {31'b0, tx}, 32'd1);
            txq.push_back(b);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_counts();
      @(posedge clk); #2;
      aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
      aw_hi_n = 0; w_hi_n = 0; ar_hi_n = 0; aw_unstable = 0;
      seen_awaddr = '0; seen_wdata = '0; seen_araddr = '0; seen_wstrb = '0;
      txq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_write(input logic [31:0] a, input logic [31:0] d);
      send_byte(8'h57, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
   endtask

   task automatic send_read(input logic [31:0] a);
      send_byte(8'h52, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
   endtask

   task automatic wait_tx(input string tag, input int n);
      for (int i = 0; i < 4000 && txq.size() < n; i++) @(negedge clk);
      check(tag, txq.size(), n);
      repeat (40) @(negedge clk);
   endtask

   task automatic check_byte(input string tag, input logic [7:0] exp);
      logic [31:0] got;
      got = (txq.size() > 0) ? {24'h0, txq.pop_front()} : 32'hFFFF_FFFF;
      check(tag, got, {24'h0, exp});
   endtask

   initial begin
      repeat (5) @(negedge clk);
      check("rst_awvalid", {31'b0, awvalid}, 0);
      check("rst_wvalid",  {31'b0, wvalid},  0);
      check("rst_arvalid", {31'b0, arvalid}, 0);
      check("rst_readies", {30'b0, bready, rready}, 0);
      check("rst_tx",      {31'b0, tx}, 1);
      check("rst_addr",    awaddr_out, 0);
      check("rst_wdata",   wdata_out, 0);
      areset = 1'b0;
      repeat (5) @(negedge clk);

      // 1: basic write
      clear_counts(); aw_delay = 0; s_bresp = 2'b00;
      send_write(32'h0000_0004, 32'hDEAD_BEEF);
      wait_tx("t1_tx_count", 1);
      check("t1_aw_hs", aw_hs_n, 1);
      check("t1_awaddr", seen_awaddr, 32'h0000_0004);
      check("t1_wdata", seen_wdata, 32'hDEAD_BEEF);
      check("t1_wstrb", {28'h0, seen_wstrb}, 32'hF);
      check("t1_prot", {26'h0, awprot_out, arprot_out}, 0);
      check("t1_b_hs", b_hs_n, 1);
      check_byte("t1_resp", 8'h00);

      // 2: basic read
      clear_counts(); s_rdata = 32'h1234_5678; s_rresp = 2'b00;
      send_read(32'h0000_0008);
      wait_tx("t2_tx_count", 5);
      check("t2_ar_hs", ar_hs_n, 1);
      check("t2_araddr", seen_araddr, 32'h0000_0008);
      check_byte("t2_resp", 8'h00);
      check_byte("t2_r0", 8'h78);
      check_byte("t2_r1", 8'h56);
      check_byte("t2_r2", 8'h34);
      check_byte("t2_r3", 8'h12);

      // 3: late awready
      clear_counts(); aw_delay = 5;
      send_write(32'h0000_0100, 32'h0BAD_F00D);
      wait_tx("t3_tx_count", 1);
      check("t3_w_hi_cycles", w_hi_n, 1);
      check("t3_aw_hi_ge5", {31'b0, aw_hi_n >= 5}, 1);
      check("t3_aw_stable", aw_unstable, 0);
      check("t3_awaddr", seen_awaddr, 32'h0000_0100);
      check("t3_b_hs", b_hs_n, 1);
      check_byte("t3_resp", 8'h00);
      aw_delay = 0;

      // 4: error responses
      clear_counts(); s_bresp = 2'b10;
      send_write(32'h0000_0020, 32'h0000_0001);
      wait_tx("t4w_tx_count", 1);
      check_byte("t4w_resp", 8'h02);
      clear_counts(); s_bresp = 2'b00; s_rresp = 2'b11; s_rdata = 32'hCAFE_F00D;
      send_read(32'h0000_0024);
      wait_tx("t4r_tx_count", 5);
      check_byte("t4r_resp", 8'h03);
      check_byte("t4r_r0", 8'h0D);
      check_byte("t4r_r1", 8'hF0);
      check_byte("t4r_r2", 8'hFE);
      check_byte("t4r_r3", 8'hCA);
      s_rresp = 2'b00;

      // 5a: junk command byte then read
      clear_counts(); s_rdata = 32'hA5A5_0001;
      send_byte(8'h41, 1'b1);
      send_read(32'h0000_000C);
      wait_tx("t5a_tx_count", 5);
      check("t5a_aw_hi", aw_hi_n, 0);
      check("t5a_ar_hs", ar_hs_n, 1);
      check("t5a_araddr", seen_araddr, 32'h0000_000C);
      check_byte("t5a_resp", 8'h00);
      check_byte("t5a_r0", 8'h01);

      // 5b: framing error on A1
      clear_counts();
      send_byte(8'h52, 1'b1);
      send_byte(8'h18, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (300) @(negedge clk);
      check("t5b_ar_hi", ar_hi_n, 0);
      check("t5b_aw_hi", aw_hi_n, 0);
      check("t5b_tx_count", txq.size(), 0);

      // 6: reset while awvalid is held
      clear_counts(); aw_delay = 1000;
      send_write(32'h0000_0200, 32'h1111_1111);
      for (int i = 0; i < 100 && !awvalid; i++) @(negedge clk);
      check("t6_awvalid_up", {31'b0, awvalid}, 1);
      repeat (3) @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      check("t6_valids", {27'b0, awvalid, wvalid, arvalid, bready, rready}, 0);
      check("t6_tx", {31'b0, tx}, 1);
      areset = 1'b0;
      aw_delay = 0;
      clear_counts(); s_rdata = 32'h55AA_33CC;
      send_read(32'h0000_0030);
      wait_tx("t6_tx_count", 5);
      check("t6_araddr", seen_araddr, 32'h0000_0030);
      check("t6_no_b", b_hs_n, 0);
      check_byte("t6_resp", 8'h00);
      check_byte("t6_r0", 8'hCC);
      check_byte("t6_r3_skip1", 8'h33);

`ifdef UART_BRIDGE_FRAME_TIMEOUT_EN
      // 7: partial frame abandoned by timeout
      clear_counts(); s_rdata = 32'h0000_0000;
      send_byte(8'h57, 1'b1);
      send_byte(8'h10, 1'b1);
      repeat (TOC + 200) @(negedge clk);
      send_read(32'h0000_0014);
      wait_tx("t7_tx_count", 5);
      check("t7_aw_hi", aw_hi_n, 0);
      check("t7_w_hi", w_hi_n, 0);
      check("t7_araddr", seen_araddr, 32'h0000_0014);
      check_byte("t7_resp", 8'h00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
